// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the Gray counter, the downstream
// Gray-to-binary converter and the bench model.
// Functions work on a 16-bit container (the widest supported counter);
// narrower callers zero-extend on the way in and truncate on the way out.
package gray_pkg;

   localparam int GRAY_WIDTH_DEFAULT = 4;
   localparam int GRAY_WIDTH_MAX     = 16;

   // Binary to reflected Gray: each Gray bit is the XOR of adjacent binary bits
   function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(input logic [GRAY_WIDTH_MAX-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
   function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(input logic [GRAY_WIDTH_MAX-1:0] gr);
      logic [GRAY_WIDTH_MAX-1:0] b;
      b[GRAY_WIDTH_MAX-1] = gr[GRAY_WIDTH_MAX-1];
      for (int i = GRAY_WIDTH_MAX-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ gr[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter feeding the Gray-to-binary stage.
// A binary count is kept internally and its Gray code is registered
// alongside it, so g never glitches between clock edges.
// Define GRAY_COUNTER_SAT_EN to make the counter saturate at its end
// values instead of wrapping; in that build the wrap pulse never fires.
module gray_counter
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] g,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};

   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] next_bin;
   logic [WIDTH-1:0] next_g;
   logic             next_wrap;

   // Next binary count and wrap flag: load beats en, en beats hold
   always_comb begin
      next_bin  = bin;
      next_wrap = 1'b0;
      if (load) begin
         next_bin = load_bin;
      end else if (en) begin
         if (up_dn) begin
`ifdef GRAY_COUNTER_SAT_EN
            if (bin != MAX_VAL) begin
               next_bin = bin + 1'b1;
            end
`else
            next_bin  = bin + 1'b1;
            next_wrap = (bin == MAX_VAL);
`endif
         end else begin
`ifdef GRAY_COUNTER_SAT_EN
            if (bin != ZERO_VAL) begin
               next_bin = bin - 1'b1;
            end
`else
            next_bin  = bin - 1'b1;
            next_wrap = (bin == ZERO_VAL);
`endif
         end
      end
      next_g = WIDTH'(bin2gray(GRAY_WIDTH_MAX'(next_bin)));
   end

   // State registers: binary count, its Gray image and the wrap pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin  <= ZERO_VAL;
         g    <= ZERO_VAL;
         wrap <= 1'b0;
      end else begin
         bin  <= next_bin;
         g    <= next_g;
         wrap <= next_wrap;
      end
   end

   assign tc = up_dn ? (bin == MAX_VAL) : (bin == ZERO_VAL);

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter at WIDTH=4.
// Expectations follow GRAY_COUNTER_SAT_EN when the bench is built with it.
module tb_gray_counter;
   import gray_pkg::*;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic         up_dn;
   logic         load;
   logic [W-1:0] load_bin;
   logic [W-1:0] g;
   logic         tc;
   logic         wrap;

   int checkCount;
   int errorCount;

   // Hand-computed Gray sequence for 16 up-steps from reset
   localparam logic [W-1:0] UP_SEQ [16] = '{
      4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
      4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000
   };

   gray_counter #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_bin (load_bin),
      .g        (g),
      .tc       (tc),
      .wrap     (wrap)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value and log mismatches
   task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the rising edge
   task automatic applyStimulus(input logic enV, input logic upV, input logic loadV, input logic [W-1:0] lbV);
      en       = enV;
      up_dn    = upV;
      load     = loadV;
      load_bin = lbV;
      @(posedge clk);
      #1;
   endtask

   // Directed sequences followed by a random walk against a binary model
   initial begin
      logic [W-1:0] expG;
      logic [W-1:0] prevG;
      logic [W-1:0] modelBin;
      logic         expWrap;
      logic         e;
      logic         u;

      checkCount = 0;
      errorCount = 0;
      rst_n      = 1'b0;
      en         = 1'b0;
      up_dn      = 1'b1;
      load       = 1'b0;
      load_bin   = '0;

      // Reset state, tc follows live up_dn
      #3;
      checkOutput("rst_g", 16'(g), 16'h0);
      checkOutput("rst_wrap", 16'(wrap), 16'h0);
      checkOutput("rst_tc_up", 16'(tc), 16'h0);
      up_dn = 1'b0;
      #1;
      checkOutput("rst_tc_dn", 16'(tc), 16'h1);
      up_dn = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // Sixteen up steps through the full sequence
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, '0);
         expG    = UP_SEQ[i];
         expWrap = (i == 15);
`ifdef GRAY_COUNTER_SAT_EN
         if (i == 15) expG = 4'b1000;
         expWrap = 1'b0;
`endif
         checkOutput($sformatf("up_g_%0d", i), 16'(g), 16'(expG));
         checkOutput($sformatf("up_wrap_%0d", i), 16'(wrap), 16'(expWrap));
         checkOutput($sformatf("up_tc_%0d", i), 16'(tc), 16'(expG == 4'b1000));
      end

      // Wrap pulse lasts one cycle only
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
`ifdef GRAY_COUNTER_SAT_EN
      checkOutput("post_wrap_g", 16'(g), 16'h8);
`else
      checkOutput("post_wrap_g", 16'(g), 16'h1);
`endif
      checkOutput("post_wrap_wrap", 16'(wrap), 16'h0);

      // Count down from a fresh reset, then reverse direction
      rst_n = 1'b0;
      #1;
      checkOutput("rst2_g", 16'(g), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      up_dn = 1'b0;
      #1;
      checkOutput("dn_tc_at0", 16'(tc), 16'h1);
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
`ifdef GRAY_COUNTER_SAT_EN
      checkOutput("dn1_g", 16'(g), 16'h0);
      checkOutput("dn1_wrap", 16'(wrap), 16'h0);
`else
      checkOutput("dn1_g", 16'(g), 16'h8);
      checkOutput("dn1_wrap", 16'(wrap), 16'h1);
`endif
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
`ifdef GRAY_COUNTER_SAT_EN
      checkOutput("dn2_g", 16'(g), 16'h0);
`else
      checkOutput("dn2_g", 16'(g), 16'h9);
`endif
      checkOutput("dn2_wrap", 16'(wrap), 16'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
`ifdef GRAY_COUNTER_SAT_EN
      checkOutput("rev1_g", 16'(g), 16'h1);
`else
      checkOutput("rev1_g", 16'(g), 16'h8);
      checkOutput("rev1_tc", 16'(tc), 16'h1);
`endif
      checkOutput("rev1_wrap", 16'(wrap), 16'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
`ifdef GRAY_COUNTER_SAT_EN
      checkOutput("rev2_g", 16'(g), 16'h3);
      checkOutput("rev2_wrap", 16'(wrap), 16'h0);
`else
      checkOutput("rev2_g", 16'(g), 16'h0);
      checkOutput("rev2_wrap", 16'(wrap), 16'h1);
`endif

      // Asynchronous reset mid-cycle clears g and wrap without an edge
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_g", 16'(g), 16'h0);
      checkOutput("async_rst_wrap", 16'(wrap), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Load beats en, then continue counting up from the loaded value
      applyStimulus(1'b1, 1'b1, 1'b1, 4'b1010);
      checkOutput("load_g", 16'(g), 16'hF);
      checkOutput("load_wrap", 16'(wrap), 16'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("after_load_g", 16'(g), 16'hE);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("hold_g", 16'(g), 16'hE);
      checkOutput("hold_wrap", 16'(wrap), 16'h0);

      // Random walk: single-bit Gray steps and end-to-end binary agreement
      modelBin = 4'd11;
      for (int i = 0; i < 60; i++) begin
         e       = 1'($urandom_range(0, 3) != 0);
         u       = 1'($urandom_range(0, 1));
         prevG   = g;
         expWrap = 1'b0;
         if (e) begin
`ifdef GRAY_COUNTER_SAT_EN
            if (u && modelBin != 4'hF) modelBin = modelBin + 4'd1;
            if (!u && modelBin != 4'h0) modelBin = modelBin - 4'd1;
`else
            expWrap  = u ? (modelBin == 4'hF) : (modelBin == 4'h0);
            modelBin = u ? modelBin + 4'd1 : modelBin - 4'd1;
`endif
         end
         applyStimulus(e, u, 1'b0, '0);
         checkOutput($sformatf("rnd_bits_%0d", i), 16'($countones(prevG ^ g) <= 1), 16'h1);
         checkOutput($sformatf("rnd_bin_%0d", i), gray2bin(16'(g)), 16'(modelBin));
         checkOutput($sformatf("rnd_wrap_%0d", i), 16'(wrap), 16'(expWrap));
      end

      // Load binary 4 (Gray 0110), then reset mid-count and restart from zero
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd4);
      checkOutput("load4_g", 16'(g), 16'h6);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_g", 16'(g), 16'h0);
      checkOutput("mid_rst_wrap", 16'(wrap), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("restart_g", 16'(g), 16'h1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
